// File: rtl/pipefetchq_pkg.sv
// Shared types and helpers for the instruction prefetch queue.
package pipe_pkg;
  typedef enum logic {RUN = 1'b0, SLOT = 1'b1} fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

  // Occupancy counter needs one extra bit to represent a full queue.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/pipefetchq_if.sv
// Fetch/decode side bundle: imem request/response plus the decode handshake.
interface pipefetchq_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  import pipe_pkg::*;
  localparam int CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] instr;
  logic             imem_ready;
  logic             redirect;
  logic [WIDTH-1:0] redirect_pc;
  logic             dq_valid;
  logic [WIDTH-1:0] dq_inst;
  logic [WIDTH-1:0] dq_pc4;
  logic             dq_ready;
  logic [CW-1:0]    count;
  logic             full;

  modport master (
    output pc, dq_valid, dq_inst, dq_pc4, count, full,
    input  instr, imem_ready, redirect, redirect_pc, dq_ready
  );

  modport slave (
    input  pc, dq_valid, dq_inst, dq_pc4, count, full,
    output instr, imem_ready, redirect, redirect_pc, dq_ready
  );
endinterface

// File: rtl/pipefetchq_fifo.sv
// Generic DEPTH x W register FIFO with flush and keep-head controls.
module pipefifo
  import pipe_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = cnt_w(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic          i_keep_head,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty
);
  logic [W-1:0]  r_mem [DEPTH];
  logic [W-1:0]  r_last;
  logic [AW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rd_nxt;

  assign o_empty  = (r_cnt == '0);
  assign o_full   = (r_cnt == CW'(DEPTH));
  assign o_count  = r_cnt;
  assign w_pop    = i_pop & ~o_empty;
  assign w_push   = i_push & ~i_flush & ~i_keep_head;
  assign w_rd_nxt = w_pop ? r_rd + AW'(1) : r_rd;
  // Empty queue keeps showing the most recently popped head.
  assign o_rdata  = o_empty ? r_last : r_mem[r_rd];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= w_rd_nxt;
      r_wr  <= w_rd_nxt;
      r_cnt <= '0;
    end else if (i_keep_head) begin
      r_rd  <= w_rd_nxt;
      r_wr  <= w_rd_nxt + AW'(1);
      r_cnt <= CW'(1);
    end else begin
      r_rd  <= w_rd_nxt;
      if (w_push) r_wr <= r_wr + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= i_wdata;
    if (w_pop)  r_last      <= r_mem[r_rd];
  end
endmodule

// File: rtl/pipefetchq.sv
// Prefetch queue: owns the fetch PC, buffers fetched words, handles redirects.
module pipefetchq
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEFAULT_RESET_PC),
  parameter bit               DELAY_SLOT = 1'b1,
  localparam int              CW         = cnt_w(DEPTH)
) (
  input logic          clock,
  input logic          reset,
  pipefetchq_if.master f
);
  fetch_state_e     r_state, w_state_nxt;
  logic [WIDTH-1:0] r_pc, w_pc_nxt, r_target;
  logic             w_pop, w_redir, w_push, w_flush, w_keep, w_save;
  logic             w_full, w_empty;
  logic [CW-1:0]    w_cnt;
  logic [2*WIDTH-1:0] w_rdata;

  assign w_pop   = f.dq_valid & f.dq_ready;
  assign w_redir = f.redirect & w_pop & (r_state == RUN);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= RUN;
      r_pc     <= RESET_PC;
      r_target <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_save) r_target <= f.redirect_pc;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:  if (w_redir && DELAY_SLOT && w_cnt == CW'(1)) w_state_nxt = SLOT;
      SLOT: if (f.imem_ready) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_push   = 1'b0;
    w_flush  = 1'b0;
    w_keep   = 1'b0;
    w_save   = 1'b0;
    w_pc_nxt = r_pc;
    case (r_state)
      RUN: begin
        if (w_redir) begin
          if (!DELAY_SLOT) begin
            w_flush  = 1'b1;
            w_pc_nxt = f.redirect_pc;
          end else if (w_cnt > CW'(1)) begin
            // Entry behind the branch is its delay slot; keep it as new head.
            w_keep   = 1'b1;
            w_pc_nxt = f.redirect_pc;
          end else begin
            // Delay slot not fetched yet: fetch it first, jump afterwards.
            w_flush  = 1'b1;
            w_save   = 1'b1;
          end
        end else if (f.imem_ready && !f.redirect && (!w_full || w_pop)) begin
          w_push   = 1'b1;
          w_pc_nxt = r_pc + WIDTH'(4);
        end
      end
      SLOT: begin
        if (f.imem_ready) begin
          w_push   = 1'b1;
          w_pc_nxt = r_target;
        end
      end
      default: ;
    endcase
  end

  pipefifo #(.W(2*WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_push),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .i_keep_head(w_keep),
    .i_wdata    ({r_pc + WIDTH'(4), f.instr}),
    .o_rdata    (w_rdata),
    .o_count    (w_cnt),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign f.pc                  = r_pc;
  assign {f.dq_pc4, f.dq_inst} = w_rdata;
  assign f.dq_valid            = ~w_empty;
  assign f.count               = w_cnt;
  assign f.full                = w_full;

  a_redirect_legal: assert property (@(posedge clock) disable iff (reset)
    f.redirect |-> (w_pop && r_state == RUN));
endmodule

// File: tb/tb_pipefetchq.sv
// Directed bench for pipefetchq: delay-slot instance A and no-delay-slot instance B.
module tb_pipefetchq;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pipefetchq_if #(.WIDTH(32), .DEPTH(4)) fa ();
  pipefetchq_if #(.WIDTH(32), .DEPTH(4)) fb ();

  // Instruction memory: word at pc is 0x1000 + pc/4.
  assign fa.instr = 32'h1000 + (fa.pc >> 2);
  assign fb.instr = 32'h1000 + (fb.pc >> 2);

  pipefetchq #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0), .DELAY_SLOT(1'b1)) dut_a (
    .clock(clk), .reset(rst_a), .f(fa.master));
  pipefetchq #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0), .DELAY_SLOT(1'b0)) dut_b (
    .clock(clk), .reset(rst_b), .f(fb.master));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    rst_a = 1'b1;
    fa.imem_ready = 1'b0; fa.dq_ready = 1'b0; fa.redirect = 1'b0; fa.redirect_pc = '0;
    step(); step();
    rst_a = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    fa.imem_ready = 1'b0; fa.dq_ready = 1'b0; fa.redirect = 1'b0; fa.redirect_pc = '0;
    fb.imem_ready = 1'b0; fb.dq_ready = 1'b0; fb.redirect = 1'b0; fb.redirect_pc = '0;
    step(); step();
    chk("rst_pc",    fa.pc, 32'h0);
    chk("rst_count", 32'(fa.count), 32'd0);
    chk("rst_valid", 32'(fa.dq_valid), 32'd0);
    chk("rst_full",  32'(fa.full), 32'd0);
    chk("rst_state", 32'(dut_a.r_state), 32'(RUN));

    // Streaming: one push and one pop per cycle.
    rst_a = 1'b0; fa.imem_ready = 1'b1; fa.dq_ready = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      step();
      chk("stream_pc4",   fa.dq_pc4, 32'(4*n));
      chk("stream_inst",  fa.dq_inst, 32'h1000 + 32'(n-1));
      chk("stream_count", 32'(fa.count), 32'd1);
    end

    // Decode stall fills the queue and freezes pc.
    reset_a(); fa.imem_ready = 1'b1;
    repeat (6) step();
    chk("stall_count", 32'(fa.count), 32'd4);
    chk("stall_full",  32'(fa.full), 32'd1);
    chk("stall_pc",    fa.pc, 32'h10);
    chk("stall_head",  fa.dq_pc4, 32'd4);
    // Full with simultaneous pop and push, across pointer wrap.
    fa.dq_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      step();
      chk("wrap_pc4",   fa.dq_pc4, 32'(8 + 4*j));
      chk("wrap_inst",  fa.dq_inst, 32'h1001 + 32'(j));
      chk("wrap_count", 32'(fa.count), 32'd4);
      chk("wrap_pc",    fa.pc, 32'(20 + 4*j));
    end
    fa.imem_ready = 1'b0;
    for (int j = 1; j <= 3; j++) begin
      step();
      chk("drain_pc4",   fa.dq_pc4, 32'(28 + 4*j));
      chk("drain_count", 32'(fa.count), 32'(4 - j));
    end
    step();
    chk("empty_valid", 32'(fa.dq_valid), 32'd0);
    chk("empty_count", 32'(fa.count), 32'd0);
    chk("empty_inst",  fa.dq_inst, 32'h1009);
    chk("empty_pc4",   fa.dq_pc4, 32'd40);
    chk("empty_pc",    fa.pc, 32'd40);

    // Delay slot redirect with count=3: keep the slot entry only.
    reset_a(); fa.imem_ready = 1'b1;
    repeat (3) step();
    chk("ds3_count0", 32'(fa.count), 32'd3);
    fa.dq_ready = 1'b1; fa.redirect = 1'b1; fa.redirect_pc = 32'h200;
    step();
    chk("ds3_count", 32'(fa.count), 32'd1);
    chk("ds3_head",  fa.dq_pc4, 32'd8);
    chk("ds3_pc",    fa.pc, 32'h200);
    fa.redirect = 1'b0; fa.dq_ready = 1'b0;
    step();
    chk("ds3_cnt2",  32'(fa.count), 32'd2);
    chk("ds3_pc2",   fa.pc, 32'h204);
    step();
    chk("ds3_cnt3",  32'(fa.count), 32'd3);
    fa.imem_ready = 1'b0; fa.dq_ready = 1'b1;
    step();
    chk("ds3_pop1_pc4",  fa.dq_pc4, 32'h204);
    chk("ds3_pop1_inst", fa.dq_inst, 32'h1080);
    step();
    chk("ds3_pop2_pc4",  fa.dq_pc4, 32'h208);
    chk("ds3_pop2_inst", fa.dq_inst, 32'h1081);
    chk("ds3_pop2_cnt",  32'(fa.count), 32'd1);

    // Delay slot redirect with count=1: slot fetch pending in SLOT.
    reset_a(); fa.imem_ready = 1'b1;
    step();
    fa.dq_ready = 1'b1; fa.redirect = 1'b1; fa.redirect_pc = 32'h400; fa.imem_ready = 1'b0;
    step();
    chk("slot_state", 32'(dut_a.r_state), 32'(SLOT));
    chk("slot_pc",    fa.pc, 32'd4);
    chk("slot_count", 32'(fa.count), 32'd0);
    chk("slot_valid", 32'(fa.dq_valid), 32'd0);
    fa.redirect = 1'b0;
    step();
    chk("slot_state2", 32'(dut_a.r_state), 32'(SLOT));
    chk("slot_pc2",    fa.pc, 32'd4);
    fa.imem_ready = 1'b1; fa.dq_ready = 1'b0;
    step();
    chk("slot_exit_state", 32'(dut_a.r_state), 32'(RUN));
    chk("slot_exit_pc",    fa.pc, 32'h400);
    chk("slot_exit_count", 32'(fa.count), 32'd1);
    chk("slot_exit_pc4",   fa.dq_pc4, 32'd8);
    chk("slot_exit_inst",  fa.dq_inst, 32'h1001);
    step();
    chk("slot_tgt_pc",  fa.pc, 32'h404);
    chk("slot_tgt_cnt", 32'(fa.count), 32'd2);

    // Reset while in SLOT discards the pending target.
    reset_a(); fa.imem_ready = 1'b1;
    step();
    fa.dq_ready = 1'b1; fa.redirect = 1'b1; fa.redirect_pc = 32'h400; fa.imem_ready = 1'b0;
    step();
    chk("rslot_state", 32'(dut_a.r_state), 32'(SLOT));
    rst_a = 1'b1; fa.redirect = 1'b0; fa.dq_ready = 1'b0; fa.imem_ready = 1'b1;
    step();
    chk("rslot_pc",    fa.pc, 32'h0);
    chk("rslot_count", 32'(fa.count), 32'd0);
    chk("rslot_valid", 32'(fa.dq_valid), 32'd0);
    chk("rslot_state2", 32'(dut_a.r_state), 32'(RUN));
    rst_a = 1'b0;
    step();
    chk("rslot_run_pc",  fa.pc, 32'd4);
    chk("rslot_run_pc4", fa.dq_pc4, 32'd4);

    // No delay slot: redirect at full flushes everything.
    rst_b = 1'b0; fb.imem_ready = 1'b1;
    repeat (4) step();
    chk("nds_full", 32'(fb.full), 32'd1);
    chk("nds_pc",   fb.pc, 32'h10);
    fb.dq_ready = 1'b1; fb.redirect = 1'b1; fb.redirect_pc = 32'h300;
    step();
    chk("nds_count", 32'(fb.count), 32'd0);
    chk("nds_valid", 32'(fb.dq_valid), 32'd0);
    chk("nds_pc2",   fb.pc, 32'h300);
    fb.redirect = 1'b0; fb.dq_ready = 1'b0;
    step();
    chk("nds_new_count", 32'(fb.count), 32'd1);
    chk("nds_new_pc4",   fb.dq_pc4, 32'h304);
    chk("nds_new_inst",  fb.dq_inst, 32'h10C0);
    chk("nds_new_pc",    fb.pc, 32'h304);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/pipefetchq.md
# pipefetchq

Parametrised instruction prefetch queue replacing the single IF/ID pipeline register of the five-stage pipeline. It owns the fetch PC, fetches one instruction per cycle from instruction memory into a DEPTH-entry FIFO, and presents {pc4, inst} to the decode stage with a valid/ready handshake. It also handles control-flow redirects, with optional MIPS delay-slot preservation, decoupling fetch from decode stalls.

## Interface
- WIDTH, 32: instruction and PC width.
- DEPTH, 4: queue entries; a power of two, at least 2.
- RESET_PC, 0: fetch PC after reset.
- DELAY_SLOT, 1: 1 keeps the instruction after a redirecting branch; 0 discards everything.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pc  out  WIDTH  current fetch address to instruction memory.
- instr  in  WIDTH  instruction at pc; valid when imem_ready=1.
- imem_ready  in  1  instruction memory returned instr for pc this cycle.
- redirect  in  1  decode stage takes a branch or jump this cycle; only legal together with a pop.
- redirect_pc  in  WIDTH  branch or jump target.
- dq_valid  out  1  head entry valid.
- dq_inst  out  WIDTH  head instruction.
- dq_pc4  out  WIDTH  head instruction address + 4.
- dq_ready  in  1  decode accepts the head (the inverse of a decode stall); a pop occurs when dq_valid and dq_ready are both 1.
- count  out  $clog2(DEPTH)+1  occupied entries.
- full  out  1  count==DEPTH.

## Operation
- Storage: DEPTH x {pc4, inst} register array, with read pointer, write pointer and count. Pointers wrap modulo DEPTH.
- State machine, two states:
  - RUN: normal fetch.
  - SLOT: one delay-slot fetch outstanding before jumping to the saved target.
- Push in RUN: when !full, imem_ready and !redirect, write {pc+4, instr} and set pc<=pc+4.
- Pop: on dq_valid & dq_ready, advance the read pointer. A push and a pop in the same cycle are both allowed at any count, including when full, and count is unchanged.
- Redirect, DELAY_SLOT=0: after the same-cycle pop, the queue is flushed (count<=0) and pc<=redirect_pc. There is no push that cycle.
- Redirect, DELAY_SLOT=1, with entries remaining after the pop: keep only the new head (count<=1, write pointer <= read pointer + 1) and set pc<=redirect_pc.
- Redirect, DELAY_SLOT=1, queue empty after the pop: count<=0, save redirect_pc in a target register, keep pc unchanged, go to SLOT.
- SLOT: when imem_ready, push {pc+4, instr}, set pc<=target and return to RUN. No other push happens in SLOT.
- Redirect while in SLOT, or redirect without a pop: ignored, and flagged by a simulation assertion.
- Outputs dq_inst and dq_pc4 are a combinational read of the head entry. When empty they hold the last head value and dq_valid=0.

## Timing
- Reset values: pc=RESET_PC, count=0, dq_valid=0, full=0, state=RUN, pointers 0, target 0. The array contents need no reset.
- Fetch-to-decode latency: an instruction pushed on edge N is visible with dq_valid=1 after edge N, i.e. in cycle N+1. This matches the single-register latency.
- Throughput: one push and one pop per cycle sustained.
- Full queue with imem_ready=1: no push, and pc holds.
- Redirect takes effect at the edge: pc shows the new value in the next cycle.
- Reset asserted mid-operation, including in SLOT: all state returns to reset values at that edge, and pending target or slot state is discarded.

## Structure
- Shared package pipe_pkg: fetch state enum {RUN, SLOT}, the default reset PC constant, and the width of count as a function of DEPTH.
- One natural sub-module, pipefifo: a generic DEPTH x W register FIFO with push, pop, flush and keep-head controls. pipefetchq wraps it with pc, target and state logic.

## Test plan
- Reset, then stream: imem returns 0x1000+k at pc=4k with dq_ready=1. Expect dq_pc4 = 4, 8, 12, ... on consecutive cycles from cycle 1, with count staying at 1.
- Decode stall: dq_ready=0 for 6 cycles. Expect count to reach DEPTH=4 with full=1 and pc frozen at 0x10. Release dq_ready and expect in-order drain with no loss or duplication.
- Redirect with DELAY_SLOT=1 and count=3: pop plus redirect to 0x200. Expect count=1 holding the slot instruction, then pushes of pc4 0x204, 0x208.
- Redirect with DELAY_SLOT=1 and count=1: pop plus redirect to 0x400 with imem_ready=0 for 2 cycles. Expect state SLOT and pc unchanged. When imem_ready rises, expect the slot instruction pushed, then pc=0x400.
- DELAY_SLOT=0, redirect at full: expect count=0 next cycle and the first new entry with dq_pc4 = redirect_pc+4.
- Full queue with a simultaneous pop and push: expect count to stay at 4 and FIFO order preserved across pointer wrap-around. Then assert reset in SLOT: expect pc=RESET_PC, count=0 and dq_valid=0.
